// File: rtl/jimmy_io_hub_if.sv
// Signal bundle between the jimmy core / external devices and the I/O hub.
// The master side is the core plus devices; the slave side is the hub itself.
interface jimmy_io_hub_if;
  // Core input direction
  logic [7:0]  in_port_0;
  logic [7:0]  in_port_1;
  logic [7:0]  in_port_2;
  logic [7:0]  in_port_3;
  logic [3:0]  in_strobe;
  // Core output direction
  logic [7:0]  out_port_0;
  logic [7:0]  out_port_1;
  logic [7:0]  out_port_2;
  logic [7:0]  out_port_3;
  logic [3:0]  out_strobe;
  // Device input side (devices push into the input FIFOs)
  logic [31:0] dev_in_data;
  logic [3:0]  dev_in_valid;
  logic [3:0]  dev_in_ready;
  // Device output side (devices drain the output FIFOs)
  logic [31:0] dev_out_data;
  logic [3:0]  dev_out_valid;
  logic [3:0]  dev_out_ready;
  // Sticky error flags
  logic [3:0]  in_underflow;
  logic [3:0]  out_overflow;

  modport master (
    input  in_port_0, in_port_1, in_port_2, in_port_3,
    output in_strobe,
    output out_port_0, out_port_1, out_port_2, out_port_3,
    output out_strobe,
    output dev_in_data, dev_in_valid,
    input  dev_in_ready,
    input  dev_out_data, dev_out_valid,
    output dev_out_ready,
    input  in_underflow, out_overflow
  );

  modport slave (
    output in_port_0, in_port_1, in_port_2, in_port_3,
    input  in_strobe,
    input  out_port_0, out_port_1, out_port_2, out_port_3,
    input  out_strobe,
    input  dev_in_data, dev_in_valid,
    output dev_in_ready,
    output dev_out_data, dev_out_valid,
    input  dev_out_ready,
    output in_underflow, out_overflow
  );
endinterface

// File: rtl/jimmy_io_hub.sv
// Peripheral-side I/O hub for the jimmy core: four input FIFOs filled by devices and
// drained by core acknowledge strobes, four output FIFOs filled by core write strobes
// and drained by devices. All FIFOs are first-word fall-through.
module jimmy_io_hub #(
  // Entries per FIFO; must be a power of two, at least 2.
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  jimmy_io_hub_if.slave  bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0] out_port_flat;
  logic [31:0] in_head_flat;
  logic [31:0] out_head_flat;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  in_uf;
  logic [3:0]  out_ovf;

  // Low for the first edge after reset release, so a strobe held low across the
  // release is not mistaken for a falling edge.
  logic armed_q;

  assign out_port_flat = {bus.out_port_3, bus.out_port_2, bus.out_port_1, bus.out_port_0};

  assign bus.in_port_0     = in_head_flat[7:0];
  assign bus.in_port_1     = in_head_flat[15:8];
  assign bus.in_port_2     = in_head_flat[23:16];
  assign bus.in_port_3     = in_head_flat[31:24];
  assign bus.dev_in_ready  = in_ready;
  assign bus.dev_out_data  = out_head_flat;
  assign bus.dev_out_valid = out_valid;
  assign bus.in_underflow  = in_uf;
  assign bus.out_overflow  = out_ovf;

  // Arm strobe edge detection one cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan

    // ------------------------------------------------------------------
    // Input direction: device pushes, core strobe pops.
    // ------------------------------------------------------------------
    logic [7:0]      in_mem [DEPTH];
    logic [PtrW-1:0] in_rd_q, in_rd_d;
    logic [PtrW-1:0] in_wr_q, in_wr_d;
    logic [CntW-1:0] in_cnt_q, in_cnt_d;
    logic            in_strobe_q;
    logic            in_uf_q, in_uf_d;
    logic            in_event;
    logic            in_empty;
    logic            in_push;
    logic            in_pop;

    assign in_event = armed_q & in_strobe_q & ~bus.in_strobe[g];
    assign in_empty = (in_cnt_q == '0);
    // Ready depends on occupancy only, so a same-cycle pop never opens the door.
    assign in_ready[g] = (in_cnt_q != Full);
    assign in_push  = bus.dev_in_valid[g] & in_ready[g];
    assign in_pop   = in_event & ~in_empty;

    assign in_head_flat[8*g +: 8] = in_empty ? 8'h00 : in_mem[in_rd_q];
    assign in_uf[g] = in_uf_q;

    // Next-state for the input FIFO pointers, count and underflow flag.
    always_comb begin
      in_rd_d  = in_rd_q;
      in_wr_d  = in_wr_q;
      in_cnt_d = in_cnt_q;
      in_uf_d  = in_uf_q;
      if (in_pop) begin
        in_rd_d = in_rd_q + PtrW'(1);
      end
      if (in_push) begin
        in_wr_d = in_wr_q + PtrW'(1);
      end
      in_cnt_d = in_cnt_q + CntW'(in_push) - CntW'(in_pop);
      if (in_event && in_empty) begin
        in_uf_d = 1'b1;
      end
    end

    // Input FIFO state registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        in_rd_q     <= '0;
        in_wr_q     <= '0;
        in_cnt_q    <= '0;
        in_strobe_q <= 1'b1;
        in_uf_q     <= 1'b0;
      end else begin
        in_rd_q     <= in_rd_d;
        in_wr_q     <= in_wr_d;
        in_cnt_q    <= in_cnt_d;
        in_strobe_q <= bus.in_strobe[g];
        in_uf_q     <= in_uf_d;
      end
    end

    // Input FIFO storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
      if (in_push) begin
        in_mem[in_wr_q] <= bus.dev_in_data[8*g +: 8];
      end
    end

    // ------------------------------------------------------------------
    // Output direction: core strobe captures, device pops.
    // ------------------------------------------------------------------
    logic [7:0]      out_mem [DEPTH];
    logic [PtrW-1:0] out_rd_q, out_rd_d;
    logic [PtrW-1:0] out_wr_q, out_wr_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            out_strobe_q;
    logic            out_ovf_q, out_ovf_d;
    logic            out_event;
    logic            out_full;
    logic            out_push;
    logic            out_pop;

    assign out_event    = armed_q & out_strobe_q & ~bus.out_strobe[g];
    assign out_full     = (out_cnt_q == Full);
    assign out_valid[g] = (out_cnt_q != '0);
    assign out_pop      = out_valid[g] & bus.dev_out_ready[g];
    // A capture into a full FIFO still lands if the head leaves in the same cycle.
    assign out_push     = out_event & (~out_full | out_pop);

    assign out_head_flat[8*g +: 8] = out_valid[g] ? out_mem[out_rd_q] : 8'h00;
    assign out_ovf[g] = out_ovf_q;

    // Next-state for the output FIFO pointers, count and overflow flag.
    always_comb begin
      out_rd_d  = out_rd_q;
      out_wr_d  = out_wr_q;
      out_cnt_d = out_cnt_q;
      out_ovf_d = out_ovf_q;
      if (out_pop) begin
        out_rd_d = out_rd_q + PtrW'(1);
      end
      if (out_push) begin
        out_wr_d = out_wr_q + PtrW'(1);
      end
      out_cnt_d = out_cnt_q + CntW'(out_push) - CntW'(out_pop);
      if (out_event && !out_push) begin
        out_ovf_d = 1'b1;
      end
    end

    // Output FIFO state registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_rd_q     <= '0;
        out_wr_q     <= '0;
        out_cnt_q    <= '0;
        out_strobe_q <= 1'b1;
        out_ovf_q    <= 1'b0;
      end else begin
        out_rd_q     <= out_rd_d;
        out_wr_q     <= out_wr_d;
        out_cnt_q    <= out_cnt_d;
        out_strobe_q <= bus.out_strobe[g];
        out_ovf_q    <= out_ovf_d;
      end
    end

    // Output FIFO storage; captures the core byte present at the strobe edge.
    always_ff @(posedge clk) begin
      if (out_push) begin
        out_mem[out_wr_q] <= out_port_flat[8*g +: 8];
      end
    end
  end

endmodule

// File: tb/tb_jimmy_io_hub.sv
// Self-checking bench for jimmy_io_hub: a queue-based reference model is advanced by the
// driver after every clock edge, and an independent monitor compares every DUT output
// against it on each falling clock edge. Directed scenarios add fixed-value checks.
module tb_jimmy_io_hub;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  jimmy_io_hub_if bus();

  jimmy_io_hub #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // Reference model: one queue per FIFO plus sticky flags and last-seen strobe levels.
  logic [7:0] in_q  [4][$];
  logic [7:0] out_q [4][$];
  logic [3:0] uf_m, ovf_m, prev_in, prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] in_port_of(input int ch);
    case (ch)
      0:       return bus.in_port_0;
      1:       return bus.in_port_1;
      2:       return bus.in_port_2;
      default: return bus.in_port_3;
    endcase
  endfunction

  function automatic logic [7:0] out_port_of(input int ch);
    case (ch)
      0:       return bus.out_port_0;
      1:       return bus.out_port_1;
      2:       return bus.out_port_2;
      default: return bus.out_port_3;
    endcase
  endfunction

  task automatic set_out_port(input int ch, input logic [7:0] v);
    case (ch)
      0:       bus.out_port_0 = v;
      1:       bus.out_port_1 = v;
      2:       bus.out_port_2 = v;
      default: bus.out_port_3 = v;
    endcase
  endtask

  task automatic reset_model();
    for (int ch = 0; ch < 4; ch++) begin
      in_q[ch].delete();
      out_q[ch].delete();
    end
    uf_m     = 4'b0000;
    ovf_m    = 4'b0000;
    prev_in  = bus.in_strobe;
    prev_out = bus.out_strobe;
  endtask

  // Apply the FIFO rules for the edge that just occurred, using the inputs it saw.
  task automatic model_edge();
    logic [7:0] tmp;
    if (!reset) begin
      prev_in  = bus.in_strobe;
      prev_out = bus.out_strobe;
      return;
    end
    for (int ch = 0; ch < 4; ch++) begin
      bit in_full, out_full, out_pop;
      in_full = (in_q[ch].size() >= DEPTH);
      if (!bus.in_strobe[ch] && prev_in[ch]) begin
        if (in_q[ch].size() > 0) tmp = in_q[ch].pop_front();
        else uf_m[ch] = 1'b1;
      end
      if (bus.dev_in_valid[ch] && !in_full) in_q[ch].push_back(bus.dev_in_data[8*ch +: 8]);

      out_full = (out_q[ch].size() >= DEPTH);
      out_pop  = (out_q[ch].size() > 0) && bus.dev_out_ready[ch];
      if (out_pop) tmp = out_q[ch].pop_front();
      if (!bus.out_strobe[ch] && prev_out[ch]) begin
        if (!out_full || out_pop) out_q[ch].push_back(out_port_of(ch));
        else ovf_m[ch] = 1'b1;
      end
    end
    prev_in  = bus.in_strobe;
    prev_out = bus.out_strobe;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic in_pulse(input int ch);
    bus.in_strobe[ch] = 1'b0;
    step();
    bus.in_strobe[ch] = 1'b1;
    step();
  endtask

  task automatic out_capture(input int ch, input logic [7:0] v);
    set_out_port(ch, v);
    step();
    bus.out_strobe[ch] = 1'b0;
    step();
    bus.out_strobe[ch] = 1'b1;
  endtask

  // Monitor: compare every visible output with the model, away from the rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0]  e_rdy, e_val;
      logic [31:0] e_od;
      for (int ch = 0; ch < 4; ch++) begin
        e_rdy[ch] = (in_q[ch].size() < DEPTH);
        e_val[ch] = (out_q[ch].size() > 0);
        e_od[8*ch +: 8] = e_val[ch] ? out_q[ch][0] : 8'h00;
        check($sformatf("mon_in_port_%0d", ch), 32'(in_port_of(ch)),
              (in_q[ch].size() > 0) ? 32'(in_q[ch][0]) : 32'h0);
      end
      check("mon_dev_in_ready", 32'(bus.dev_in_ready), 32'(e_rdy));
      check("mon_dev_out_valid", 32'(bus.dev_out_valid), 32'(e_val));
      check("mon_dev_out_data", bus.dev_out_data, e_od);
      check("mon_in_underflow", 32'(bus.in_underflow), 32'(uf_m));
      check("mon_out_overflow", 32'(bus.out_overflow), 32'(ovf_m));
    end
  end

  initial begin
    bus.in_strobe     = 4'hF;
    bus.out_strobe    = 4'hF;
    bus.out_port_0    = 8'h00;
    bus.out_port_1    = 8'h00;
    bus.out_port_2    = 8'h00;
    bus.out_port_3    = 8'h00;
    bus.dev_in_data   = 32'h0;
    bus.dev_in_valid  = 4'h0;
    bus.dev_out_ready = 4'h0;
    #2 reset = 1'b0;
    reset_model();
    mon_en = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Input fill and drain on channel 2.
    bus.dev_in_valid[2] = 1'b1;
    bus.dev_in_data[23:16] = 8'hA1;
    step();
    bus.dev_in_data[23:16] = 8'hB2;
    step();
    bus.dev_in_valid[2] = 1'b0;
    check("fill_head_a1", 32'(bus.in_port_2), 32'hA1);
    in_pulse(2);
    check("drain_head_b2", 32'(bus.in_port_2), 32'hB2);
    in_pulse(2);
    check("drain_empty", 32'(bus.in_port_2), 32'h00);
    check("drain_ready", 32'(bus.dev_in_ready[2]), 32'h1);

    // Input full on channel 0, then pop with a waiting fifth byte.
    bus.dev_in_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.dev_in_data[7:0] = 8'hC0 + 8'(i);
      step();
    end
    bus.dev_in_data[7:0] = 8'hC4;
    step();
    step();
    check("full_ready", 32'(bus.dev_in_ready[0]), 32'h0);
    check("full_head", 32'(bus.in_port_0), 32'hC0);
    bus.in_strobe[0] = 1'b0;
    step();
    check("full_ready_back", 32'(bus.dev_in_ready[0]), 32'h1);
    step();
    bus.in_strobe[0] = 1'b1;
    bus.dev_in_valid[0] = 1'b0;
    check("full_again", 32'(bus.dev_in_ready[0]), 32'h0);
    check("full_order_c1", 32'(bus.in_port_0), 32'hC1);
    step();
    in_pulse(0);
    check("full_order_c2", 32'(bus.in_port_0), 32'hC2);
    in_pulse(0);
    check("full_order_c3", 32'(bus.in_port_0), 32'hC3);
    in_pulse(0);
    check("full_order_c4", 32'(bus.in_port_0), 32'hC4);
    in_pulse(0);
    check("full_order_empty", 32'(bus.in_port_0), 32'h00);

    // Underflow with a long strobe on channel 1.
    bus.in_strobe[1] = 1'b0;
    repeat (3) step();
    bus.in_strobe[1] = 1'b1;
    step();
    check("underflow_flag", 32'(bus.in_underflow), 32'h2);
    bus.dev_in_valid[1] = 1'b1;
    bus.dev_in_data[15:8] = 8'h5C;
    step();
    bus.dev_in_valid[1] = 1'b0;
    check("underflow_push", 32'(bus.in_port_1), 32'h5C);
    in_pulse(1);

    // Output capture on channel 3.
    out_capture(3, 8'h7E);
    check("cap_valid", 32'(bus.dev_out_valid[3]), 32'h1);
    check("cap_data", 32'(bus.dev_out_data[31:24]), 32'h7E);
    bus.dev_out_ready[3] = 1'b1;
    step();
    bus.dev_out_ready[3] = 1'b0;
    check("cap_drained", 32'(bus.dev_out_valid[3]), 32'h0);

    // Output overflow versus simultaneous pop on channel 0.
    for (int i = 0; i < 4; i++) out_capture(0, 8'h10 + 8'(i));
    set_out_port(0, 8'h99);
    step();
    bus.out_strobe[0] = 1'b0;
    bus.dev_out_ready[0] = 1'b1;
    step();
    bus.out_strobe[0] = 1'b1;
    bus.dev_out_ready[0] = 1'b0;
    check("ovf_none", 32'(bus.out_overflow), 32'h0);
    out_capture(0, 8'h55);
    check("ovf_set", 32'(bus.out_overflow), 32'h1);
    bus.dev_out_ready[0] = 1'b1;
    check("ovf_head_11", 32'(bus.dev_out_data[7:0]), 32'h11);
    step();
    check("ovf_head_12", 32'(bus.dev_out_data[7:0]), 32'h12);
    step();
    check("ovf_head_13", 32'(bus.dev_out_data[7:0]), 32'h13);
    step();
    check("ovf_tail_99", 32'(bus.dev_out_data[7:0]), 32'h99);
    step();
    bus.dev_out_ready[0] = 1'b0;
    check("ovf_no_55", 32'(bus.dev_out_valid[0]), 32'h0);

    // Async reset mid-traffic with every FIFO non-empty.
    bus.dev_in_valid = 4'hF;
    bus.dev_in_data  = 32'h8899AABB;
    step();
    bus.dev_in_valid = 4'h0;
    for (int ch = 0; ch < 4; ch++) set_out_port(ch, 8'h60 + 8'(ch));
    step();
    bus.out_strobe = 4'h0;
    step();
    bus.out_strobe = 4'hF;
    check("pre_reset_valid", 32'(bus.dev_out_valid), 32'hF);
    #2 reset = 1'b0;
    reset_model();
    #1;
    check("rst_in_port_0", 32'(bus.in_port_0), 32'h0);
    check("rst_in_port_3", 32'(bus.in_port_3), 32'h0);
    check("rst_out_data", bus.dev_out_data, 32'h0);
    check("rst_out_valid", 32'(bus.dev_out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.dev_in_ready), 32'hF);
    check("rst_underflow", 32'(bus.in_underflow), 32'h0);
    check("rst_overflow", 32'(bus.out_overflow), 32'h0);
    step();
    // Strobe held low across the release must not count as an event.
    bus.in_strobe[1] = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    bus.in_strobe[1] = 1'b1;
    step();
    check("rst_held_strobe", 32'(bus.in_underflow), 32'h0);
    in_pulse(1);
    check("rst_first_edge", 32'(bus.in_underflow), 32'h2);

    // Randomized traffic on all channels.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.dev_in_valid  = 4'($urandom);
      bus.dev_in_data   = $urandom;
      bus.dev_out_ready = 4'($urandom | $urandom);
      bus.in_strobe     = 4'($urandom | $urandom);
      bus.out_strobe    = 4'($urandom | $urandom);
      for (int ch = 0; ch < 4; ch++) set_out_port(ch, 8'($urandom));
      step();
    end

    bus.in_strobe  = 4'hF;
    bus.out_strobe = 4'hF;
    step();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jimmy_io_hub.md
# jimmy_io_hub

Peripheral-side I/O hub for the `jimmy` core. It sits on the far end of the core's four input ports, four output ports and their active-low strobes.
- **Input direction:** four per-channel FIFOs are filled by external devices through valid/ready. Each FIFO head is presented on `in_port_N`, and the head is popped when the core acknowledges consumption on `in_strobe[N]`.
- **Output direction:** a byte written by the core is captured from `out_port_N` when `out_strobe[N]` is asserted. It is queued in a per-channel FIFO and drained by external devices through valid/ready.

## Interface
- `DEPTH`, default 4: entries per channel FIFO, in each direction. Must be a power of two, at least 2.
- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-low; clears all state.
- `in_port_0..in_port_3`  output  8 each  head of input FIFO N; 8'h00 when that FIFO is empty.
- `in_strobe`  input  4  core input acknowledge, active-low, one bit per channel.
- `out_port_0..out_port_3`  input  8 each  core output data.
- `out_strobe`  input  4  core output strobe, active-low, one bit per channel.
- `dev_in_data`  input  32  device data; channel N on bits [8N+7:8N].
- `dev_in_valid`  input  4  device offers a byte on channel N.
- `dev_in_ready`  output  4  input FIFO N is not full.
- `dev_out_data`  output  32  head of output FIFO N on bits [8N+7:8N]; 8'h00 when empty.
- `dev_out_valid`  output  4  output FIFO N is not empty.
- `dev_out_ready`  input  4  device accepts the byte on channel N.
- `in_underflow`  output  4  sticky; the core acknowledged channel N while its input FIFO was empty.
- `out_overflow`  output  4  sticky; the core wrote channel N while its output FIFO was full and no pop occurred.

## Operation
- **Channels:** eight independent circular FIFOs (4 in, 4 out), each with DEPTH entries.
- **FIFO state:** per FIFO, a read pointer and a write pointer of log2(DEPTH) bits, plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Strobe detection:** a registered copy of each strobe (`in_strobe_q`, `out_strobe_q`) resets to 1. An event is defined as strobe==0 && strobe_q==1, i.e. a falling edge. A strobe held low for several cycles produces exactly one event.
- **Input push:** occurs when dev_in_valid[N] && dev_in_ready[N] at a clock edge. dev_in_ready[N] = (count < DEPTH) and depends only on count, never on strobes.
- **Input pop:** occurs on an in_strobe[N] event with count > 0. A pop and a push in the same cycle both take effect and the count is unchanged.
- **Input pop when empty:** an event with count == 0 sets in_underflow[N]; no pop. If a push lands in that same cycle, the push still takes effect.
- **Output capture:** occurs on an out_strobe[N] event. The byte captured is the value of out_port_N at that clock edge.
- **Output pop:** occurs when dev_out_valid[N] && dev_out_ready[N].
- **Output full case:** a capture while count == DEPTH succeeds only if a pop occurs in the same cycle (count stays DEPTH). Otherwise the byte is dropped and out_overflow[N] is set.
- **Head outputs:** in_port_N and dev_out_data[N] are combinational reads of storage at the read pointer, gated to 8'h00 when the FIFO is empty (first-word fall-through).
- **Sticky flags:** cleared only by reset.
- **Reset state (all outputs):**
  - all pointers and counts 0;
  - strobe copies 1;
  - in_port_* = 8'h00, dev_out_data = 0, dev_out_valid = 4'b0000;
  - dev_in_ready = 4'b1111;
  - in_underflow = out_overflow = 4'b0000;
  - storage contents don't-care.
- **Reset mid-operation:** all queued bytes are discarded. A strobe held low across the reset release produces no event.

## Timing
- Push to visibility: a byte pushed at edge k appears on in_port_N / dev_out_data[N] after edge k (zero extra latency).
- Pop to head advance: the head advances immediately after the popping edge.
- Core sequence: the core samples in_port_N in EXECUTE and drives in_strobe low for the following WRITE_BACK cycle. The pop at that strobe's falling edge therefore removes exactly the byte the core read.
- Output capture: the core updates out_port_N in EXECUTE and asserts out_strobe one cycle later, so the captured byte is stable.
- dev_out_valid[N] rises on the edge after the capture.
- Throughput: one push and one pop per FIFO per cycle.

## Test plan
- **Input fill and drain:** reset, then push 8'hA1, 8'hB2 on channel 2. in_port_2 = 8'hA1. After one in_strobe[2] low pulse, in_port_2 = 8'hB2. After a second pulse, in_port_2 = 8'h00 and dev_in_ready[2] = 1.
- **Input full:** push DEPTH=4 bytes on channel 0 → dev_in_ready[0] = 0; a 5th valid is not accepted. Then pulse in_strobe[0] with dev_in_valid[0] held → ready returns, count = 4 again, and the 5th byte is last in order.
- **Underflow and long strobe:** hold in_strobe[1] low 3 cycles on an empty FIFO → in_underflow = 4'b0010 after one event only. A subsequent push of 8'h5C is visible on in_port_1.
- **Output capture:** out_port_3 = 8'h7E, pulse out_strobe[3] → dev_out_valid[3] = 1 and dev_out_data[31:24] = 8'h7E. With dev_out_ready[3] high for one cycle → valid drops to 0.
- **Output overflow vs. simultaneous pop:** fill channel 0 with 4 bytes, then capture 8'h99 with dev_out_ready[0] = 1 → no overflow and 8'h99 lands at the tail. Capture 8'h55 with ready = 0 → out_overflow[0] = 1 and 8'h55 is absent.
- **Async reset mid-traffic:** assert reset between clock edges with all FIFOs non-empty → outputs reach their reset values immediately, with no clock edge required. After release, the first strobe falling edge behaves normally.
